// File: rtl/fir_pkg.sv
// Shared types and default bus widths for the symmetric FIR sequencer, the filter and the benches.
package fir_pkg;

    localparam int COEFF_WIDTH  = 8;
    localparam int DATA_WIDTH   = 12;
    localparam int OUTPUT_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        FLUSH
    } fir_state_e;

endpackage

// File: rtl/symmetric_fir_ctrl_if.sv
// Stream, command and filter-side signals of the symmetric FIR sequencer.
// The master modport is the surrounding environment and the slave modport is the sequencer.
interface symmetric_fir_ctrl_if;
    import fir_pkg::*;

    logic                           cfg_start;
    logic                           coeff_valid;
    logic                           coeff_ready;
    logic signed [COEFF_WIDTH-1:0]  coeff_data;
    logic                           s_valid;
    logic                           s_ready;
    logic signed [DATA_WIDTH-1:0]   s_data;
    logic                           flush;
    logic                           fir_clr;
    logic                           fir_load;
    logic signed [COEFF_WIDTH-1:0]  fir_coeff;
    logic signed [DATA_WIDTH-1:0]   fir_sample;
    logic signed [OUTPUT_WIDTH-1:0] fir_out;
    logic                           m_valid;
    logic signed [OUTPUT_WIDTH-1:0] m_data;
    logic                           busy;
    logic                           done;

    modport master (
        output cfg_start, coeff_valid, coeff_data, s_valid, s_data, flush, fir_out,
        input  coeff_ready, s_ready, fir_clr, fir_load, fir_coeff, fir_sample,
               m_valid, m_data, busy, done
    );

    modport slave (
        input  cfg_start, coeff_valid, coeff_data, s_valid, s_data, flush, fir_out,
        output coeff_ready, s_ready, fir_clr, fir_load, fir_coeff, fir_sample,
               m_valid, m_data, busy, done
    );

endinterface

// File: rtl/fir_valid_tag.sv
// Valid-bit delay line that lines up the "sample accepted" tag with the filter pipeline.
module fir_valid_tag #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_tag;

    // NOTE: clocked state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[DEPTH-2:0], i_valid};
        end
    end

    assign o_valid = r_tag[DEPTH-1];

endmodule

// File: rtl/symmetric_fir_ctrl.sv
// Sequencer for the symmetric FIR: clear, serial coefficient load, sample streaming and flush drain.
// Output valid is a tag delayed alongside the filter pipeline; data words pass through untouched.
module symmetric_fir_ctrl
    import fir_pkg::*;
#(
    parameter int COEFF_NUM  = 6,
    parameter int DATA_DELAY = 2 * COEFF_NUM,
    parameter int PIPE_LAT   = 4
) (
    input  logic                clk,
    input  logic                clr,
    symmetric_fir_ctrl_if.slave bus
);

    localparam int FLUSH_CYCLES = DATA_DELAY + PIPE_LAT + 1;
    localparam int CNT_MAX      = (FLUSH_CYCLES > COEFF_NUM) ? FLUSH_CYCLES : COEFF_NUM;
    localparam int CNT_W        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(COEFF_NUM - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    fir_state_e r_state;
    fir_state_e w_next_state;

    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               w_next_cnt;
    logic signed [OUTPUT_WIDTH-1:0] r_m_data;

    logic                           w_fir_clr;
    logic                           w_fir_load;
    logic signed [COEFF_WIDTH-1:0]  w_fir_coeff;
    logic signed [DATA_WIDTH-1:0]   w_fir_sample;
    logic                           w_coeff_ready;
    logic                           w_s_ready;
    logic                           w_tag_in;
    logic                           w_tag_clr;
    logic                           w_tag_tail;
    logic                           w_done;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == RUN || r_state == FLUSH) begin
                r_m_data <= bus.fir_out;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_fir_clr     = clr;
        w_fir_load    = 1'b0;
        w_fir_coeff   = '0;
        w_fir_sample  = '0;
        w_coeff_ready = 1'b0;
        w_s_ready     = 1'b0;
        w_tag_in      = 1'b0;
        w_done        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.cfg_start) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_fir_clr    = 1'b1;
                w_next_cnt   = '0;
                w_next_state = LOAD;
            end
            LOAD: begin
                // Pass-through so the filter takes the coefficient on the handshake edge.
                w_coeff_ready = 1'b1;
                w_fir_load    = bus.coeff_valid;
                w_fir_coeff   = bus.coeff_data;
                if (bus.coeff_valid) begin
                    if (r_cnt == LOAD_LAST) begin
                        w_next_cnt   = '0;
                        w_next_state = RUN;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                w_s_ready    = 1'b1;
                w_tag_in     = bus.s_valid;
                w_fir_sample = bus.s_valid ? bus.s_data : '0;
                if (bus.flush) begin
                    w_next_cnt   = '0;
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_done       = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_tag_clr = clr || (r_state == CLEAR);

    // The tag's last stage is the output valid, so the handshake-to-m_valid delay is PIPE_LAT+1.
    fir_valid_tag #(
        .DEPTH (PIPE_LAT + 1)
    ) u_valid_tag (
        .clk     (clk),
        .i_clr   (w_tag_clr),
        .i_valid (w_tag_in),
        .o_valid (w_tag_tail)
    );

    assign bus.coeff_ready = w_coeff_ready;
    assign bus.s_ready     = w_s_ready;
    assign bus.fir_clr     = w_fir_clr;
    assign bus.fir_load    = w_fir_load;
    assign bus.fir_coeff   = w_fir_coeff;
    assign bus.fir_sample  = w_fir_sample;
    assign bus.m_valid     = w_tag_tail;
    assign bus.m_data      = r_m_data;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = w_done;

endmodule

// File: tb/tb_symmetric_fir_ctrl.sv
// Directed bench for symmetric_fir_ctrl; a behavioural symmetric FIR with a 4-cycle pipeline
// sits on the filter side so m_data can be compared against hand-computed responses.
module tb_symmetric_fir_ctrl;
    import fir_pkg::*;

    localparam int COEFF_NUM    = 6;
    localparam int DATA_DELAY   = 12;
    localparam int PIPE_LAT     = 4;
    localparam int FLUSH_CYCLES = DATA_DELAY + PIPE_LAT + 1;

    typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
    typedef coeff_t coeff_set_t [COEFF_NUM];

    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    symmetric_fir_ctrl_if bus ();

    symmetric_fir_ctrl #(
        .COEFF_NUM  (COEFF_NUM),
        .DATA_DELAY (DATA_DELAY),
        .PIPE_LAT   (PIPE_LAT)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Filter model: coefficients shift in at tap 0, delay line folded symmetrically,
    // three output registers after the combinational sum give PIPE_LAT=4 cycles.
    coeff_t                          f_coeff [COEFF_NUM];
    logic signed [DATA_WIDTH-1:0]    f_dl    [DATA_DELAY];
    logic signed [OUTPUT_WIDTH-1:0]  f_pipe  [3];
    logic signed [OUTPUT_WIDTH-1:0]  f_acc;
    int                              f_sum;

    always_comb begin
        f_sum = 0;
        for (int k = 0; k < COEFF_NUM; k++) begin
            f_sum = f_sum + int'(f_coeff[k]) * (int'(f_dl[k]) + int'(f_dl[DATA_DELAY-1-k]));
        end
        f_acc = OUTPUT_WIDTH'(f_sum);
    end

    always @(posedge clk) begin
        if (bus.fir_clr) begin
            for (int i = 0; i < COEFF_NUM; i++) f_coeff[i] <= '0;
            for (int i = 0; i < DATA_DELAY; i++) f_dl[i] <= '0;
            for (int i = 0; i < 3; i++) f_pipe[i] <= '0;
        end else begin
            if (bus.fir_load) begin
                f_coeff[0] <= bus.fir_coeff;
                for (int i = 1; i < COEFF_NUM; i++) f_coeff[i] <= f_coeff[i-1];
            end
            f_dl[0] <= bus.fir_sample;
            for (int i = 1; i < DATA_DELAY; i++) f_dl[i] <= f_dl[i-1];
            f_pipe[0] <= f_acc;
            f_pipe[1] <= f_pipe[0];
            f_pipe[2] <= f_pipe[1];
        end
    end

    assign bus.fir_out = f_pipe[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input coeff_set_t c);
        bus.cfg_start = 1'b1;
        next_cycle();
        bus.cfg_start = 1'b0;
        next_cycle();
        for (int i = 0; i < COEFF_NUM; i++) begin
            bus.coeff_valid = 1'b1;
            bus.coeff_data  = c[i];
            next_cycle();
        end
        bus.coeff_valid = 1'b0;
        bus.coeff_data  = '0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.fir_clr !== 1'b1) begin
                errors++;
                $display("FAIL reset_fir_clr cycle %0d: got %b expected 1", i, bus.fir_clr);
            end
            checks++;
            if ({bus.busy, bus.m_valid, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_status cycle %0d: busy/m_valid/done got %b%b%b expected 000",
                         i, bus.busy, bus.m_valid, bus.done);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({bus.coeff_ready, bus.s_ready, bus.fir_load} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: coeff_ready/s_ready/fir_load got %b%b%b expected 000",
                     bus.coeff_ready, bus.s_ready, bus.fir_load);
        end
        checks++;
        if (bus.fir_coeff !== '0 || bus.fir_sample !== '0 || bus.m_data !== '0) begin
            errors++;
            $display("FAIL reset_data: fir_coeff=%0d fir_sample=%0d m_data=%0d expected all 0",
                     bus.fir_coeff, bus.fir_sample, bus.m_data);
        end
        clr = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.fir_clr !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: fir_clr=%b busy=%b expected 0 0", bus.fir_clr, bus.busy);
        end
        next_cycle();
    endtask

    task automatic test_idle_flush();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.fir_clr !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: busy=%b fir_clr=%b expected 0 0", bus.busy, bus.fir_clr);
        end
        next_cycle();
    endtask

    task automatic test_load();
        coeff_set_t lc;
        int sent, loads, clrs, cyc;
        logic exp_load;
        lc = '{8'sd1, -8'sd2, 8'sd3, -8'sd4, 8'sd5, -8'sd6};
        sent = 0;
        loads = 0;
        clrs = 0;
        cyc = 0;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        if (bus.fir_clr === 1'b1) clrs++;
        next_cycle();
        bus.cfg_start = 1'b0;
        @(negedge clk);
        if (bus.fir_clr === 1'b1) clrs++;
        checks++;
        if (bus.fir_clr !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_clear_cycle: fir_clr=%b busy=%b expected 1 1", bus.fir_clr, bus.busy);
        end
        next_cycle();
        while (sent < COEFF_NUM && cyc < 12) begin
            exp_load = (cyc != 2);
            if (exp_load) begin
                bus.coeff_valid = 1'b1;
                bus.coeff_data  = lc[sent];
                bus.flush       = 1'b0;
                bus.cfg_start   = 1'b0;
            end else begin
                bus.coeff_valid = 1'b0;
                bus.coeff_data  = 8'sh55;
                bus.flush       = 1'b1;
                bus.cfg_start   = 1'b1;
            end
            @(negedge clk);
            if (bus.fir_clr === 1'b1) clrs++;
            if (bus.fir_load === 1'b1) loads++;
            checks++;
            if (bus.coeff_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL load_ready cycle %0d: coeff_ready=%b s_ready=%b expected 1 0",
                         cyc, bus.coeff_ready, bus.s_ready);
            end
            checks++;
            if (bus.fir_load !== exp_load) begin
                errors++;
                $display("FAIL load_strobe cycle %0d: fir_load=%b expected %b", cyc, bus.fir_load, exp_load);
            end
            if (exp_load) begin
                checks++;
                if (bus.fir_coeff !== lc[sent]) begin
                    errors++;
                    $display("FAIL load_coeff %0d: fir_coeff=%0d expected %0d", sent, bus.fir_coeff, lc[sent]);
                end
                sent++;
            end
            next_cycle();
            cyc++;
        end
        bus.coeff_valid = 1'b0;
        bus.coeff_data  = '0;
        bus.flush       = 1'b0;
        bus.cfg_start   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.coeff_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_to_run: s_ready=%b coeff_ready=%b busy=%b expected 1 0 1",
                     bus.s_ready, bus.coeff_ready, bus.busy);
        end
        checks++;
        if (loads !== COEFF_NUM) begin
            errors++;
            $display("FAIL load_count: fir_load cycles=%0d expected %0d", loads, COEFF_NUM);
        end
        checks++;
        if (clrs !== 1) begin
            errors++;
            $display("FAIL load_clr_count: fir_clr cycles=%0d expected 1", clrs);
        end
        next_cycle();
    endtask

    task automatic test_run_ignores_cfg();
        bus.cfg_start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fir_clr !== 1'b0) begin
            errors++;
            $display("FAIL run_cfg_clr: fir_clr=%b expected 0", bus.fir_clr);
        end
        next_cycle();
        bus.cfg_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.fir_clr !== 1'b0 || bus.coeff_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_cfg_state: s_ready=%b fir_clr=%b coeff_ready=%b expected 1 0 0",
                     bus.s_ready, bus.fir_clr, bus.coeff_ready);
        end
        next_cycle();
    endtask

    task automatic test_gapped();
        bit                             sv [6];
        logic signed [DATA_WIDTH-1:0]   sd [6];
        logic signed [DATA_WIDTH-1:0]   exp_sample;
        logic signed [OUTPUT_WIDTH-1:0] exp_md;
        logic                           exp_v;
        int                             pulses;
        sv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sd = '{12'sh100, 12'sh555, 12'sh200, 12'sh2AA, 12'sh7FF, 12'sh300};
        pulses = 0;
        for (int t = 0; t < 30; t++) begin
            if (t < 6) begin
                bus.s_valid = sv[t];
                bus.s_data  = sd[t];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = 12'sh123;
            end
            @(negedge clk);
            exp_sample = '0;
            if (t < 6 && sv[t]) exp_sample = sd[t];
            checks++;
            if (bus.fir_sample !== exp_sample) begin
                errors++;
                $display("FAIL gapped_sample t=%0d: fir_sample=%0h expected %0h", t, bus.fir_sample, exp_sample);
            end
            exp_v = 1'b0;
            if (t >= PIPE_LAT + 1 && t < PIPE_LAT + 7) exp_v = sv[t-PIPE_LAT-1];
            checks++;
            if (bus.m_valid !== exp_v) begin
                errors++;
                $display("FAIL gapped_m_valid t=%0d: m_valid=%b expected %b", t, bus.m_valid, exp_v);
            end
            if (bus.m_valid === 1'b1) pulses++;
            if (exp_v) begin
                case (t)
                    5:       exp_md = -24'sd1536;
                    7:       exp_md = -24'sd4096;
                    default: exp_md = -24'sd2816;
                endcase
                checks++;
                if (bus.m_data !== exp_md) begin
                    errors++;
                    $display("FAIL gapped_m_data t=%0d: m_data=%0d expected %0d", t, bus.m_data, exp_md);
                end
            end
            next_cycle();
        end
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL gapped_pulse_count: m_valid pulses=%0d expected 3", pulses);
        end
    endtask

    task automatic test_flush();
        int   done_count, pulses;
        logic exp_busy;
        done_count = 0;
        pulses = 0;
        for (int t = 0; t < 25; t++) begin
            bus.s_valid = (t < 2);
            bus.s_data  = (t == 0) ? 12'sh7FF : 12'sh3FF;
            bus.flush   = (t == 0);
            @(negedge clk);
            checks++;
            if (bus.s_ready !== (t == 0)) begin
                errors++;
                $display("FAIL flush_s_ready t=%0d: s_ready=%b expected %b", t, bus.s_ready, (t == 0));
            end
            if (t == 1) begin
                checks++;
                if (bus.fir_sample !== '0) begin
                    errors++;
                    $display("FAIL flush_sample_zero: fir_sample=%0h expected 0", bus.fir_sample);
                end
            end
            checks++;
            if (bus.m_valid !== (t == PIPE_LAT + 1)) begin
                errors++;
                $display("FAIL flush_m_valid t=%0d: m_valid=%b expected %b", t, bus.m_valid, (t == PIPE_LAT + 1));
            end
            if (bus.m_valid === 1'b1) pulses++;
            if (t == PIPE_LAT + 1) begin
                checks++;
                if (bus.m_data !== -24'sd12282) begin
                    errors++;
                    $display("FAIL flush_m_data: m_data=%0d expected -12282", bus.m_data);
                end
            end
            checks++;
            if (bus.done !== (t == FLUSH_CYCLES)) begin
                errors++;
                $display("FAIL flush_done t=%0d: done=%b expected %b", t, bus.done, (t == FLUSH_CYCLES));
            end
            if (bus.done === 1'b1) done_count++;
            exp_busy = (t <= FLUSH_CYCLES);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL flush_busy t=%0d: busy=%b expected %b", t, bus.busy, exp_busy);
            end
            next_cycle();
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        checks++;
        if (done_count !== 1 || pulses !== 1) begin
            errors++;
            $display("FAIL flush_counts: done pulses=%0d m_valid pulses=%0d expected 1 1", done_count, pulses);
        end
    endtask

    task automatic test_impulse();
        coeff_set_t                     ones;
        logic signed [OUTPUT_WIDTH-1:0] exp_md;
        logic                           seen;
        ones = '{default: 8'sd1};
        do_load(ones);
        for (int t = 0; t < 25; t++) begin
            bus.s_valid = (t == 0);
            bus.s_data  = (t == 0) ? 12'sd1 : 12'sd0;
            @(negedge clk);
            checks++;
            if (bus.m_valid !== (t == PIPE_LAT + 1)) begin
                errors++;
                $display("FAIL impulse_m_valid t=%0d: m_valid=%b expected %b", t, bus.m_valid, (t == PIPE_LAT + 1));
            end
            exp_md = (t >= 5 && t <= 16) ? 24'sd1 : 24'sd0;
            checks++;
            if (bus.m_data !== exp_md) begin
                errors++;
                $display("FAIL impulse_m_data t=%0d: m_data=%0d expected %0d", t, bus.m_data, exp_md);
            end
            next_cycle();
        end
        bus.s_valid = 1'b0;
        bus.flush   = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
            next_cycle();
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL impulse_flush_done: done=%b within 40 cycles, expected 1", seen);
        end
    endtask

    task automatic test_reset_mid_run();
        coeff_set_t lc;
        int         bad;
        lc = '{8'sd1, -8'sd2, 8'sd3, -8'sd4, 8'sd5, -8'sd6};
        bad = 0;
        do_load(lc);
        for (int t = 0; t < 3; t++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DATA_WIDTH'(16 * (t + 1));
            next_cycle();
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fir_clr !== 1'b1) begin
            errors++;
            $display("FAIL midrun_clr_first: fir_clr=%b expected 1", bus.fir_clr);
        end
        next_cycle();
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.fir_clr, bus.busy, bus.m_valid, bus.done, bus.s_ready} !== 5'b10000) begin
                errors++;
                $display("FAIL midrun_clr cycle %0d: fir_clr/busy/m_valid/done/s_ready=%b%b%b%b%b expected 10000",
                         i, bus.fir_clr, bus.busy, bus.m_valid, bus.done, bus.s_ready);
            end
            next_cycle();
        end
        clr = 1'b0;
        bus.s_valid = 1'b0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrun_after: %0d cycles with done/m_valid/busy set, expected 0", bad);
        end
    endtask

    initial begin
        clr             = 1'b1;
        bus.cfg_start   = 1'b0;
        bus.coeff_valid = 1'b0;
        bus.coeff_data  = '0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.flush       = 1'b0;
        test_reset();
        test_idle_flush();
        test_load();
        test_run_ignores_cfg();
        test_gapped();
        test_flush();
        test_impulse();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units");
        $fatal(1);
    end

endmodule
